cache_line_refill_engine: RTL and testbench
===========================================

Name: cache_line_refill_engine

Overview:
Parametrised line-miss engine between a direct-mapped cache and the single-beat external memory port. It accepts one miss request at a time. If the victim line is dirty, it writes the whole line back first, then refills the missing line word by word. Fill order is either linear or critical-word-first with wrap, and the critical word is presented early so the pipeline can restart before the fill completes.

Parameters:
WORD_SIZE, 32, bits per bus beat/word
BYTES_PER_WORD, 4, address stride per beat (power of 2)
WORDS_PER_LINE, 16, beats per line (power of 2, >=2)
ADDR_WIDTH, 32, address width
WRAP_FILL, 1, 1 = critical-word-first wrapping fill; 0 = linear fill from word 0
LINE_BITS, WORD_SIZE*WORDS_PER_LINE, derived line data width
OFF_BITS, log2(WORDS_PER_LINE*BYTES_PER_WORD), derived line offset width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  miss request
req_ready  out  1  high only in IDLE; request accepted on edge with req_valid&req_ready
miss_addr  in  ADDR_WIDTH  byte address of the missing access
evict_dirty  in  1  victim line must be written back
evict_addr  in  ADDR_WIDTH  victim line address (low OFF_BITS ignored)
evict_line  in  LINE_BITS  victim data; word i at [i*WORD_SIZE +: WORD_SIZE]
ext_addr  out  ADDR_WIDTH  beat address
ext_re  out  1  read strobe
ext_wr  out  1  write strobe
ext_data_out  out  WORD_SIZE  write data
ext_data_in  in  WORD_SIZE  read data, valid with ext_ack
ext_ack  in  1  beat complete on this edge
crit_valid  out  1  one-cycle pulse: critical word available
crit_data  out  WORD_SIZE  critical word; held until next request is accepted
fill_line  out  LINE_BITS  assembled line, same packing as evict_line; held until next request is accepted
done  out  1  one-cycle pulse: fill_line complete
busy  out  1  ~req_ready

Behaviour:
- Reset (sync, rst high on edge): state=IDLE, all counters 0, all outputs 0 except req_ready=1. rst wins over every other input. An in-flight operation is abandoned: strobes are low from the cycle after the edge, and no done/crit_valid is issued.
- States: IDLE, WB, FILL, DONE. Outputs decode from registered state, counters and captured request only (no input-to-output combinational path).
- On accept: latch miss_addr, evict_addr and evict_line; clear fill_line and crit_data.
  - Next state is WB if evict_dirty, else FILL.
  - req_valid outside IDLE is ignored.
- Addresses:
  - base = addr with the low OFF_BITS cleared.
  - beat addr = base + idx*BYTES_PER_WORD.
  - crit_idx = miss_addr[OFF_BITS-1 : log2(BYTES_PER_WORD)].
- WB:
  - ext_wr=1, ext_re=0, idx runs 0..WORDS_PER_LINE-1.
  - ext_data_out = latched evict word idx, ext_addr = evict beat addr.
  - Strobe, addr and data are held stable until ext_ack.
  - On an ack edge, idx increments. The last ack goes to FILL with idx reset.
  - Back-to-back: the next beat is presented in the cycle after the ack, with the strobe held high.
- FILL:
  - ext_re=1, ext_wr=0.
  - Start word: s = crit_idx if WRAP_FILL else 0. Beat k reads word (s+k) mod WORDS_PER_LINE, wrapping within the line.
  - On each ack, ext_data_in is written into that word slot of fill_line.
  - On the first ack (k=0): if WRAP_FILL, crit_data <= ext_data_in and crit_valid pulses next cycle. If WRAP_FILL=0, crit_valid pulses in the cycle after the ack of beat crit_idx, with that word.
  - The ack of beat WORDS_PER_LINE-1 goes to DONE.
- DONE: strobes 0, done=1 for exactly one cycle, then IDLE. fill_line is complete and stable while done is high.
- ext_ack is ignored in IDLE and DONE, and whenever no strobe is high. ext_re and ext_wr are never high together.
- No ack means wait indefinitely (no timeout).
- Latency with zero-wait memory (ack in first strobe cycle):
  - Clean miss: accept edge, N beat cycles, 1 DONE cycle.
  - Dirty miss: adds N WB cycles.

Test Plan:
- Clean, WRAP_FILL=1, WORDS_PER_LINE=4: miss_addr=0x0000_1048, memory returns 0xA0..0xA3 for words 0..3, ack every cycle -> reads at 0x1048, 0x104C, 0x1040, 0x1044. crit_valid with crit_data=0xA2 one cycle after the first ack. done 4 cycles after the first strobe. fill_line={A3,A2,A1,A0}.
- Dirty, evict_addr=0x2000, evict_line={D3,D2,D1,D0}, miss_addr=0x3004 -> writes D0..D3 to 0x2000..0x200C in order, then reads starting at 0x3004. No cycle with both strobes high.
- Wait states: ack only every 3rd cycle -> ext_addr and ext_data_out are stable across stalls; no beat is skipped or duplicated.
- WRAP_FILL=0, miss_addr=0x100C -> reads 0x1000..0x100C; crit_valid follows the 4th ack.
- rst asserted mid-FILL after 2 acks -> next cycle strobes=0, req_ready=1, done never pulses. A new request then completes normally.
- req_valid held high during busy; ext_ack pulsed while idle -> a single operation only, and idle acks have no effect.

Source files
------------

// File: rtl/cache_line_refill_engine_if.sv
// Signal bundle between a cache miss requester / external memory and the line refill engine.
// The engine takes the slave modport; the requester-plus-memory side takes the master modport.
interface cache_line_refill_engine_if #(
   parameter int WORD_SIZE      = 32,
   parameter int WORDS_PER_LINE = 16,
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_BITS      = WORD_SIZE * WORDS_PER_LINE
);
   // Request handshake: a miss transfers on the rising edge where req_valid && req_ready are both
   // high; req_valid must not wait on req_ready, and the request fields are sampled only on that edge.
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] miss_addr;
   logic                  evict_dirty;
   logic [ADDR_WIDTH-1:0] evict_addr;
   logic [LINE_BITS-1:0]  evict_line;

   // Memory beat: a strobe with address (and write data) stays stable until the edge with ext_ack.
   logic [ADDR_WIDTH-1:0] ext_addr;
   logic                  ext_re;
   logic                  ext_wr;
   logic [WORD_SIZE-1:0]  ext_data_out;
   logic [WORD_SIZE-1:0]  ext_data_in;
   logic                  ext_ack;

   logic                  crit_valid;
   logic [WORD_SIZE-1:0]  crit_data;
   logic [LINE_BITS-1:0]  fill_line;
   logic                  done;
   logic                  busy;

   modport master (
      output req_valid, miss_addr, evict_dirty, evict_addr, evict_line, ext_data_in, ext_ack,
      input  req_ready, ext_addr, ext_re, ext_wr, ext_data_out, crit_valid, crit_data,
             fill_line, done, busy
   );

   modport slave (
      input  req_valid, miss_addr, evict_dirty, evict_addr, evict_line, ext_data_in, ext_ack,
      output req_ready, ext_addr, ext_re, ext_wr, ext_data_out, crit_valid, crit_data,
             fill_line, done, busy
   );
endinterface

// File: rtl/cache_line_refill_engine.sv
// Line-miss engine: optional dirty-victim write-back, then a word-by-word refill that is either
// linear or critical-word-first with wrap, presenting the critical word as soon as it arrives.
module cache_line_refill_engine #(
   parameter int WORD_SIZE      = 32,
   parameter int BYTES_PER_WORD = 4,
   parameter int WORDS_PER_LINE = 16,
   parameter int ADDR_WIDTH     = 32,
   parameter bit WRAP_FILL      = 1'b1,
   parameter int LINE_BITS      = WORD_SIZE * WORDS_PER_LINE,
   parameter int OFF_BITS       = $clog2(WORDS_PER_LINE * BYTES_PER_WORD)
) (
   input  logic                        clk,
   input  logic                        rst,
   cache_line_refill_engine_if.slave   bus,
   output logic [1:0]                  dbg_state
);
   localparam int BYTE_BITS = $clog2(BYTES_PER_WORD);
   localparam int IDX_BITS  = $clog2(WORDS_PER_LINE);
   localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS_PER_LINE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   logic [IDX_BITS-1:0]  idx;
   logic [IDX_BITS-1:0]  crit_idx;
   logic [TAG_BITS-1:0]  miss_tag;
   logic [TAG_BITS-1:0]  evict_tag;
   logic [LINE_BITS-1:0] evict_data;
   logic [LINE_BITS-1:0] fill_data;
   logic [WORD_SIZE-1:0] crit_word;
   logic                 crit_pulse;
   logic [IDX_BITS-1:0]  fill_start;
   logic [IDX_BITS-1:0]  fill_word;
   logic                 last_beat;
   logic                 unused_addr_bits;

   function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TAG_BITS-1:0] tag,
                                                       input logic [IDX_BITS-1:0] word);
      beat_addr = {tag, {OFF_BITS{1'b0}}} + (ADDR_WIDTH'(word) << BYTE_BITS);
   endfunction

   assign last_beat  = (idx == LAST_IDX);
   assign fill_start = WRAP_FILL ? crit_idx : '0;
   // Adding in IDX_BITS width wraps the fill order inside the line for free.
   assign fill_word  = fill_start + idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         crit_idx   <= '0;
         miss_tag   <= '0;
         evict_tag  <= '0;
         evict_data <= '0;
         fill_data  <= '0;
         crit_word  <= '0;
         crit_pulse <= 1'b0;
      end else begin
         crit_pulse <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  miss_tag   <= bus.miss_addr[ADDR_WIDTH-1 -: TAG_BITS];
                  crit_idx   <= bus.miss_addr[BYTE_BITS +: IDX_BITS];
                  evict_tag  <= bus.evict_addr[ADDR_WIDTH-1 -: TAG_BITS];
                  evict_data <= bus.evict_line;
                  fill_data  <= '0;
                  crit_word  <= '0;
                  idx        <= '0;
                  state      <= bus.evict_dirty ? WB : FILL;
               end
            end
            WB: begin
               // idx rolls over to 0 on the last beat, ready for the fill.
               if (bus.ext_ack) begin
                  idx <= idx + 1'b1;
                  if (last_beat) state <= FILL;
               end
            end
            FILL: begin
               if (bus.ext_ack) begin
                  fill_data[int'(fill_word) * WORD_SIZE +: WORD_SIZE] <= bus.ext_data_in;
                  if (fill_word == crit_idx) begin
                     crit_word  <= bus.ext_data_in;
                     crit_pulse <= 1'b1;
                  end
                  idx <= idx + 1'b1;
                  if (last_beat) state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ext_addr     = '0;
      bus.ext_data_out = '0;
      case (state)
         WB: begin
            bus.ext_addr     = beat_addr(evict_tag, idx);
            bus.ext_data_out = evict_data[int'(idx) * WORD_SIZE +: WORD_SIZE];
         end
         FILL: bus.ext_addr = beat_addr(miss_tag, fill_word);
         default: ;
      endcase
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.busy       = (state != IDLE);
   assign bus.ext_wr     = (state == WB);
   assign bus.ext_re     = (state == FILL);
   assign bus.done       = (state == DONE);
   assign bus.crit_valid = crit_pulse;
   assign bus.crit_data  = crit_word;
   assign bus.fill_line  = fill_data;
   assign dbg_state      = state;

   // Byte-offset bits below the word (and the victim's line offset) carry no meaning here.
   assign unused_addr_bits = ^{bus.miss_addr, bus.evict_addr};
endmodule

// File: tb/tb_cache_line_refill_engine.sv
// Bench: a wrapping-fill and a linear-fill engine share one stimulus stream; a transaction-level
// model predicts every beat, pulse and assembled line, and directed cases pin literal results.
module tb_cache_line_refill_engine;
   localparam int WS  = 32;
   localparam int BPW = 4;
   localparam int WPL = 4;
   localparam int AW  = 32;
   localparam int LB  = WS * WPL;
   localparam int OFF = 4;
   localparam logic [AW-1:0] LMASK = ~AW'((1 << OFF) - 1);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0;
   logic [AW-1:0] miss_addr = '0;
   logic          evict_dirty = 1'b0;
   logic [AW-1:0] evict_addr = '0;
   logic [LB-1:0] evict_line = '0;
   logic          ack = 1'b0;
   logic [WS-1:0] salt = '0;
   int            ack_mode = 0;
   logic [1:0]    dbg0, dbg1;

   function automatic logic [WS-1:0] mem_word(input logic [AW-1:0] a, input logic [WS-1:0] s);
      return ((a >> 4) * s) ^ (32'hA0 + ((a >> 2) & 32'h3));
   endfunction

   cache_line_refill_engine_if #(.WORD_SIZE(WS), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)) bus0 ();
   cache_line_refill_engine_if #(.WORD_SIZE(WS), .WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.req_valid = req_valid;   assign bus1.req_valid = req_valid;
   assign bus0.miss_addr = miss_addr;   assign bus1.miss_addr = miss_addr;
   assign bus0.evict_dirty = evict_dirty; assign bus1.evict_dirty = evict_dirty;
   assign bus0.evict_addr = evict_addr; assign bus1.evict_addr = evict_addr;
   assign bus0.evict_line = evict_line; assign bus1.evict_line = evict_line;
   assign bus0.ext_ack = ack;           assign bus1.ext_ack = ack;
   assign bus0.ext_data_in = mem_word(bus0.ext_addr, salt);
   assign bus1.ext_data_in = mem_word(bus1.ext_addr, salt);

   cache_line_refill_engine #(.WORD_SIZE(WS), .BYTES_PER_WORD(BPW), .WORDS_PER_LINE(WPL),
      .ADDR_WIDTH(AW), .WRAP_FILL(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0));
   cache_line_refill_engine #(.WORD_SIZE(WS), .BYTES_PER_WORD(BPW), .WORDS_PER_LINE(WPL),
      .ADDR_WIDTH(AW), .WRAP_FILL(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

   logic          o_re[2], o_wr[2], o_ready[2], o_busy[2], o_crit[2], o_done[2];
   logic [AW-1:0] o_addr[2];
   logic [WS-1:0] o_wdata[2], o_cdata[2];
   logic [LB-1:0] o_line[2];
   assign o_re[0] = bus0.ext_re;        assign o_re[1] = bus1.ext_re;
   assign o_wr[0] = bus0.ext_wr;        assign o_wr[1] = bus1.ext_wr;
   assign o_ready[0] = bus0.req_ready;  assign o_ready[1] = bus1.req_ready;
   assign o_busy[0] = bus0.busy;        assign o_busy[1] = bus1.busy;
   assign o_crit[0] = bus0.crit_valid;  assign o_crit[1] = bus1.crit_valid;
   assign o_done[0] = bus0.done;        assign o_done[1] = bus1.done;
   assign o_addr[0] = bus0.ext_addr;    assign o_addr[1] = bus1.ext_addr;
   assign o_wdata[0] = bus0.ext_data_out; assign o_wdata[1] = bus1.ext_data_out;
   assign o_cdata[0] = bus0.crit_data;  assign o_cdata[1] = bus1.crit_data;
   assign o_line[0] = bus0.fill_line;   assign o_line[1] = bus1.fill_line;

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_fail = 0;
   logic [LB-1:0] exp_q[$];
   logic [WS-1:0] exp_crit_q[$];

   int            m_phase[2];      // 0 idle, 1 beats in flight, 2 done cycle
   int            m_k[2], m_n[2], m_crit_beat[2];
   logic          m_crit_due[2];
   logic          m_wr[2][8];
   logic [AW-1:0] m_addr[2][8];
   logic [WS-1:0] m_data[2][8];
   logic          m_started = 1'b0;
   logic          m_rst_seen = 1'b0;

   task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      m_started  <= 1'b1;
      m_rst_seen <= rst;
      if (rst) begin
         exp_q.delete();
         exp_crit_q.delete();
      end
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_phase[i]    <= 0;
            m_crit_due[i] <= 1'b0;
         end else begin
            m_crit_due[i] <= 1'b0;
            if (m_phase[i] == 0) begin
               if (req_valid) begin
                  automatic int nwb = evict_dirty ? WPL : 0;
                  automatic int ci  = int'((miss_addr / BPW) % WPL);
                  automatic int s   = (i == 0) ? ci : 0;
                  automatic logic [AW-1:0] mb = miss_addr & LMASK;
                  automatic logic [AW-1:0] eb = evict_addr & LMASK;
                  automatic logic [LB-1:0] ln = '0;
                  for (int w = 0; w < WPL; w++) begin
                     m_wr[i][w]   <= 1'b1;
                     m_addr[i][w] <= eb + AW'(w * BPW);
                     m_data[i][w] <= evict_line[w*WS +: WS];
                  end
                  for (int k = 0; k < WPL; k++) begin
                     m_wr[i][nwb+k]   <= 1'b0;
                     m_addr[i][nwb+k] <= mb + AW'(((s + k) % WPL) * BPW);
                     m_data[i][nwb+k] <= '0;
                  end
                  m_n[i]         <= nwb + WPL;
                  m_k[i]         <= 0;
                  m_crit_beat[i] <= nwb + ((i == 0) ? 0 : ci);
                  m_phase[i]     <= 1;
                  if (i == 0) begin
                     for (int w = 0; w < WPL; w++) ln[w*WS +: WS] = mem_word(mb + AW'(w * BPW), salt);
                     exp_q.push_back(ln);
                     exp_crit_q.push_back(mem_word(mb + AW'(ci * BPW), salt));
                  end
               end
            end else if (m_phase[i] == 1) begin
               if (ack) begin
                  if (m_k[i] == m_crit_beat[i]) m_crit_due[i] <= 1'b1;
                  if (m_k[i] + 1 == m_n[i]) m_phase[i] <= 2;
                  m_k[i] <= m_k[i] + 1;
               end
            end else begin
               m_phase[i] <= 0;
            end
         end
      end
   end

   // Logs and timestamps used by the directed literal checks.
   int            cyc = 0;
   int            first_stb = -1, crit_cyc0 = -1, crit_cyc1 = -1, done_cyc0 = -1, done_count = 0;
   logic [WS-1:0] crit_val0 = '0;
   logic [LB-1:0] fill0 = '0;
   logic [AW-1:0] rd_log0[$], rd_log1[$], wr_addr_log0[$];
   logic [WS-1:0] wr_data_log0[$];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (m_started) begin
            for (int i = 0; i < 2; i++) begin
               automatic logic exp_re = 1'b0;
               automatic logic exp_wr = 1'b0;
               automatic string tag = $sformatf("inst%0d", i);
               if (m_phase[i] == 1) begin
                  exp_wr = m_wr[i][m_k[i]];
                  exp_re = !m_wr[i][m_k[i]];
               end
               chk({tag, " req_ready"}, LB'(o_ready[i]), LB'(m_phase[i] == 0));
               chk({tag, " busy"}, LB'(o_busy[i]), LB'(m_phase[i] != 0));
               chk({tag, " ext_re"}, LB'(o_re[i]), LB'(exp_re));
               chk({tag, " ext_wr"}, LB'(o_wr[i]), LB'(exp_wr));
               chk({tag, " strobe_excl"}, LB'(o_re[i] & o_wr[i]), LB'(0));
               if (m_phase[i] == 1) begin
                  chk({tag, " ext_addr"}, LB'(o_addr[i]), LB'(m_addr[i][m_k[i]]));
                  if (exp_wr) chk({tag, " ext_data_out"}, LB'(o_wdata[i]), LB'(m_data[i][m_k[i]]));
               end
               chk({tag, " crit_valid"}, LB'(o_crit[i]), LB'(m_crit_due[i]));
               if (m_crit_due[i] && exp_crit_q.size() > 0)
                  chk({tag, " crit_data"}, LB'(o_cdata[i]), LB'(exp_crit_q[0]));
               chk({tag, " done"}, LB'(o_done[i]), LB'(m_phase[i] == 2));
               if (m_phase[i] == 2 && exp_q.size() > 0) begin
                  chk({tag, " fill_line"}, o_line[i], exp_q[0]);
                  chk({tag, " crit_held"}, LB'(o_cdata[i]), LB'(exp_crit_q[0]));
               end
               if (m_rst_seen) begin
                  chk({tag, " reset_fill_line"}, o_line[i], LB'(0));
                  chk({tag, " reset_crit_data"}, LB'(o_cdata[i]), LB'(0));
               end
            end
            if (o_re[0] && ack) rd_log0.push_back(o_addr[0]);
            if (o_re[1] && ack) rd_log1.push_back(o_addr[1]);
            if (o_wr[0] && ack) begin
               wr_addr_log0.push_back(o_addr[0]);
               wr_data_log0.push_back(o_wdata[0]);
            end
            if ((o_re[0] || o_wr[0]) && first_stb < 0) first_stb = cyc;
            if (o_crit[0]) begin crit_cyc0 = cyc; crit_val0 = o_cdata[0]; end
            if (o_crit[1]) crit_cyc1 = cyc;
            if (o_done[0]) begin done_cyc0 = cyc; fill0 = o_line[0]; done_count++; end
            if (m_phase[0] == 2 && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               void'(exp_crit_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         case (ack_mode)
            0: ack = 1'b1;
            1: ack = ((cyc % 3) == 2);
            default: ack = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic clear_logs();
      rd_log0.delete(); rd_log1.delete(); wr_addr_log0.delete(); wr_data_log0.delete();
      first_stb = -1; crit_cyc0 = -1; crit_cyc1 = -1; done_cyc0 = -1; done_count = 0;
   endtask

   task automatic start_req(input logic [AW-1:0] ma, input logic dirty, input logic [AW-1:0] ea,
                            input logic [LB-1:0] el, input bit hold);
      miss_addr = ma; evict_dirty = dirty; evict_addr = ea; evict_line = el;
      req_valid = 1'b1;
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic wait_idle(input bit hold);
      int t;
      for (t = 0; t < 3000; t++) begin
         if (m_phase[0] == 0 && m_phase[1] == 0) break;
         if (hold) begin
            if (m_phase[0] == 2) req_valid = 1'b0;
            else begin
               miss_addr = $urandom; evict_dirty = 1'($urandom_range(0, 1));
               evict_addr = $urandom; evict_line = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      chk("op_timeout", LB'(t < 3000), LB'(1));
   endtask

   task automatic do_req(input logic [AW-1:0] ma, input logic dirty, input logic [AW-1:0] ea,
                         input logic [LB-1:0] el, input bit hold);
      start_req(ma, dirty, ea, el, hold);
      wait_idle(hold);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Clean wrapping miss at 0x1048 with data 0xA0+word.
      salt = '0; ack_mode = 0; clear_logs();
      do_req(32'h0000_1048, 1'b0, '0, '0, 1'b0);
      chk("t1 rd_count", LB'(rd_log0.size()), LB'(4));
      chk("t1 rd0", LB'(rd_log0[0]), LB'(32'h1048));
      chk("t1 rd1", LB'(rd_log0[1]), LB'(32'h104C));
      chk("t1 rd2", LB'(rd_log0[2]), LB'(32'h1040));
      chk("t1 rd3", LB'(rd_log0[3]), LB'(32'h1044));
      chk("t1 crit_val", LB'(crit_val0), LB'(32'hA2));
      chk("t1 crit_lat", LB'(crit_cyc0 - first_stb), LB'(1));
      chk("t1 done_lat", LB'(done_cyc0 - first_stb), LB'(4));
      chk("t1 line", fill0, 128'h000000A3_000000A2_000000A1_000000A0);
      chk("t1 lin_rd0", LB'(rd_log1[0]), LB'(32'h1040));
      chk("t1 lin_crit_lat", LB'(crit_cyc1 - first_stb), LB'(3));

      // Dirty miss: write-back of D0..D3, then the fill.
      clear_logs();
      do_req(32'h0000_3004, 1'b1, 32'h0000_2000,
             128'h000000D3_000000D2_000000D1_000000D0, 1'b0);
      chk("t2 wr_count", LB'(wr_addr_log0.size()), LB'(4));
      for (int w = 0; w < WPL; w++) begin
         chk($sformatf("t2 wr_addr%0d", w), LB'(wr_addr_log0[w]), LB'(32'h2000 + 4 * w));
         chk($sformatf("t2 wr_data%0d", w), LB'(wr_data_log0[w]), LB'(32'hD0 + w));
      end
      chk("t2 first_rd", LB'(rd_log0[0]), LB'(32'h3004));

      // Wait states on a dirty wrapping miss.
      ack_mode = 1; salt = 32'h1357_9BDF;
      do_req(32'h0000_5A3E, 1'b1, 32'h0000_7F00, {$urandom, $urandom, $urandom, $urandom}, 1'b0);

      // Linear fill with the critical word last.
      ack_mode = 0; salt = '0; clear_logs();
      do_req(32'h0000_100C, 1'b0, '0, '0, 1'b0);
      for (int k = 0; k < WPL; k++)
         chk($sformatf("t4 lin_rd%0d", k), LB'(rd_log1[k]), LB'(32'h1000 + 4 * k));
      chk("t4 lin_crit_lat", LB'(crit_cyc1 - first_stb), LB'(4));

      // Reset after two fill acks, then a normal request.
      clear_logs();
      start_req(32'h0000_4444, 1'b0, '0, '0, 1'b0);
      for (int t = 0; t < 100; t++) begin
         if (m_phase[0] == 1 && m_k[0] == 2) break;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5 re_after_rst", LB'(o_re[0]), LB'(0));
      chk("t5 ready_after_rst", LB'(o_ready[0]), LB'(1));
      chk("t5 no_done", LB'(done_count), LB'(0));
      do_req(32'h0000_4444, 1'b1, 32'h0000_8880, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      chk("t5 done_after", LB'(done_count), LB'(1));

      // req_valid held through busy (fields scrambled), acks toggling while idle.
      clear_logs(); ack_mode = 2;
      repeat (5) @(posedge clk);
      #1;
      do_req(32'h0000_6128, 1'b1, 32'h0000_9900, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      repeat (6) @(posedge clk);
      #1;
      chk("t6 single_op", LB'(done_count), LB'(1));

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         ack_mode = $urandom_range(0, 2);
         salt = $urandom;
         do_req($urandom, 1'($urandom_range(0, 1)), $urandom,
                {$urandom, $urandom, $urandom, $urandom}, bit'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
